// File: rtl/ram_bist_ctrl.sv
// Purpose: march-test initiator for one RAM port; reports pass/fail plus the first failing address and data.
// Latency: a clean run keeps busy high for 6*2^ADDR_W cycles; each lost write adds 2 cycles.
// Backpressure: a write without wr_ack is re-issued, and after MAX_RETRY consecutive misses the test stops with ack_err.
module ram_bist_ctrl #(
    parameter int                  ADDR_W    = 11,
    parameter int                  DATA_W    = 8,
    parameter logic [DATA_W-1:0]   SEED      = 8'hA5,
    parameter int                  MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              ack_err,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    input  logic              wr_ack,
    input  logic [DATA_W-1:0] rd_data
);

    localparam int                RW  = $clog2(MAX_RETRY + 1);
    localparam logic [ADDR_W-1:0] TOP = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {IDLE, WR, WR_ACK, RD, RDW, RDW_ACK, RDN, FIN} state_t;

    state_t            state;
    logic [RW-1:0]     retry_cnt;
    logic [DATA_W-1:0] exp_dat;
    logic              mismatch;

    // Seed pattern: address zero-extended (or truncated) to the data width, then XORed with the seed.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        logic [ADDR_W+DATA_W-1:0] wide;
        wide = {{DATA_W{1'b0}}, a};
        return wide[DATA_W-1:0] ^ SEED;
    endfunction

    // Expected read data: plain pattern in the ascending pass, inverse pattern in the descending pass.
    always_comb begin
        exp_dat = pat(address);
        if (state == RDN) begin
            exp_dat = ~pat(address);
        end
    end

    assign mismatch = (rd_data != exp_dat);

    // March sequencer. Every output is registered and set up for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            retry_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            ack_err   <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            address   <= '0;
            data_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        ack_err   <= 1'b0;
                        fail_addr <= '0;
                        fail_exp  <= '0;
                        fail_got  <= '0;
                        retry_cnt <= '0;
                        address   <= '0;
                        wr_en     <= 1'b1;
                        data_out  <= pat('0);
                        state     <= WR;
                    end
                end
                WR: begin
                    wr_en <= 1'b0;
                    state <= WR_ACK;
                end
                RDW: begin
                    wr_en <= 1'b0;
                    state <= RDW_ACK;
                end
                WR_ACK, RDW_ACK: begin
                    if (wr_ack) begin
                        retry_cnt <= '0;
                        if (state == WR_ACK) begin
                            if (address == TOP) begin
                                address <= '0;
                                rd_en   <= 1'b1;
                                state   <= RD;
                            end else begin
                                address  <= address + 1'b1;
                                data_out <= pat(address + 1'b1);
                                wr_en    <= 1'b1;
                                state    <= WR;
                            end
                        end else begin
                            // Address holds at TOP when entering the descending pass.
                            rd_en <= 1'b1;
                            if (address == TOP) begin
                                state <= RDN;
                            end else begin
                                address <= address + 1'b1;
                                state   <= RD;
                            end
                        end
                    end else if (retry_cnt == RW'(MAX_RETRY - 1)) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        ack_err   <= 1'b1;
                        fail_addr <= address;
                        state     <= FIN;
                    end else begin
                        // Lost arbitration: re-issue the same write; data_out still holds its data.
                        retry_cnt <= retry_cnt + 1'b1;
                        wr_en     <= 1'b1;
                        state     <= (state == WR_ACK) ? WR : RDW;
                    end
                end
                RD, RDN: begin
                    if (mismatch) begin
                        rd_en     <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= address;
                        fail_exp  <= exp_dat;
                        fail_got  <= rd_data;
                        state     <= FIN;
                    end else if (state == RD) begin
                        rd_en    <= 1'b0;
                        wr_en    <= 1'b1;
                        data_out <= ~pat(address);
                        state    <= RDW;
                    end else if (address == '0) begin
                        rd_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                        state <= FIN;
                    end else begin
                        address <= address - 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Purpose: bench for ram_bist_ctrl against a behavioural RAM port with injectable port-B collisions and read faults.
// Latency: each run's result is scored when done rises, using the expectation queued at start.
// Backpressure: a collision makes port B win that write, so wr_ack stays low for the attempt.
module tb_ram_bist_ctrl;

    localparam int          AW   = 4;
    localparam int          DW   = 8;
    localparam int          N    = 16;
    localparam logic [7:0]  SEED = 8'hA5;

    typedef struct {
        int busy_len;
        int pass;
        int ack_err;
        int fail_addr;
        int fail_exp;
        int fail_got;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, pass, ack_err;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_got;
    logic          wr_en, rd_en;
    logic [AW-1:0] address;
    logic [DW-1:0] data_out;
    logic          wr_ack;
    logic [DW-1:0] rd_data;

    int   errors = 0;
    int   checks = 0;
    int   strobe_err = 0;
    exp_t exp_q[$];

    logic [DW-1:0] mem [0:N-1];
    logic [AW-1:0] collide_addr;
    int            collide_req;
    int            collide_used;
    bit            flip_en;
    logic          collide;

    ram_bist_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .SEED     (SEED),
        .MAX_RETRY(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .ack_err  (ack_err),
        .fail_addr(fail_addr),
        .fail_exp (fail_exp),
        .fail_got (fail_got),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .address  (address),
        .data_out (data_out),
        .wr_ack   (wr_ack),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    // RAM port: port B wins a write to collide_addr for the first collide_req attempts of a run.
    assign collide = wr_en && (address == collide_addr) && (collide_used < collide_req);
    assign rd_data = mem[address] ^ ((flip_en && rd_en && address == 4'd5) ? 8'h01 : 8'h00);

    always @(posedge clk) begin
        if (start) collide_used <= 0;
        else if (collide) collide_used <= collide_used + 1;
        wr_ack <= wr_en && !collide;
        if (wr_en) mem[address] <= collide ? 8'h3C : data_out;
    end

    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        return {4'b0000, a} ^ SEED;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: measure busy length, watch strobe rules, score each run when done rises.
    logic busy_q = 1'b0;
    logic done_q = 1'b0;
    int   busy_cnt = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (busy && !busy_q) busy_cnt = 1;
        else if (busy) busy_cnt++;
        if (wr_en && rd_en) strobe_err++;
        if ((wr_en || rd_en) && !busy) strobe_err++;
        if (done === 1'b1 && done_q !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("busy_len",  busy_cnt,  e.busy_len);
                check("pass",      pass,      e.pass);
                check("ack_err",   ack_err,   e.ack_err);
                check("fail_addr", fail_addr, e.fail_addr);
                check("fail_exp",  fail_exp,  e.fail_exp);
                check("fail_got",  fail_got,  e.fail_got);
            end
        end
        busy_q = busy;
        done_q = done;
    end

    task automatic run(input exp_t e, input bit mid_start);
        int c;
        exp_q.push_back(e);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        c = 0;
        while (c < 2000 && done !== 1'b1) begin
            @(negedge clk);
            start = (mid_start && c == 20);
            c++;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            check("run_timeout", 0, 1);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic check_final_mem(input string name);
        int bad = 0;
        for (int a = 0; a < N; a++) begin
            if (mem[a] !== ~pat(AW'(a))) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, pass, ack_err, fail_addr, fail_exp, fail_got,
                     wr_en, rd_en, address, data_out}, 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        int   c;
        reset = 1'b1;
        start = 1'b0;
        flip_en = 1'b0;
        collide_req = 0;
        collide_addr = '0;
        for (int a = 0; a < N; a++) mem[a] = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // 1: clean run
        e = '{busy_len: 96, pass: 1, ack_err: 0, fail_addr: 0, fail_exp: 0, fail_got: 0};
        run(e, 1'b0);
        check("mem3_after_clean", mem[3], 8'h59);
        check_final_mem("final_mem_clean");
        check("done_held", done, 1);

        // 2: read fault on address 5 in the ascending read pass
        flip_en = 1'b1;
        e = '{busy_len: 48, pass: 0, ack_err: 0, fail_addr: 5, fail_exp: 8'hA0, fail_got: 8'hA1};
        run(e, 1'b0);
        flip_en = 1'b0;

        // 3: one lost write at address 7
        collide_addr = 4'd7;
        collide_req  = 1;
        e = '{busy_len: 98, pass: 1, ack_err: 0, fail_addr: 0, fail_exp: 0, fail_got: 0};
        run(e, 1'b0);
        check_final_mem("final_mem_retry");

        // 4: three lost writes at address 2
        collide_addr = 4'd2;
        collide_req  = 3;
        e = '{busy_len: 10, pass: 0, ack_err: 1, fail_addr: 2, fail_exp: 0, fail_got: 0};
        run(e, 1'b0);
        collide_req = 0;

        // 5: reset during the read+write-inverse pass
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        c = 0;
        while (c < 1000 && !(wr_en === 1'b1 && data_out === ~pat(address))) begin
            @(negedge clk);
            c++;
        end
        check("reached_rdw", wr_en && (data_out === ~pat(address)), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("mid_reset_outputs");
        repeat (5) @(negedge clk);
        check("idle_after_reset", {busy, wr_en, rd_en}, 0);
        e = '{busy_len: 96, pass: 1, ack_err: 0, fail_addr: 0, fail_exp: 0, fail_got: 0};
        run(e, 1'b0);
        check_final_mem("final_mem_after_reset");

        // 6: start pulsed while busy is ignored
        e = '{busy_len: 96, pass: 1, ack_err: 0, fail_addr: 0, fail_exp: 0, fail_got: 0};
        run(e, 1'b1);
        repeat (3) @(negedge clk);
        check("no_restart", busy, 0);

        check("strobe_rules", strobe_err, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
